// File: rtl/frame_buf_sched_if.sv
// frame_buf_sched_if: bundles calibration, camera/display frame strobes, load pulses, bank windows, frame_valid and event counters between scheduler and its user
interface frame_buf_sched_if;
  logic        init_calib_complete;
  logic        wr_frame_start;
  logic        wr_word_valid;
  logic        rd_frame_start;
  logic        wr_load;
  logic        rd_load;
  logic [28:0] wr_addr_min;
  logic [28:0] wr_addr_max;
  logic [28:0] rd_addr_min;
  logic [28:0] rd_addr_max;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic        frame_valid;
  logic [15:0] ovw_cnt;
  logic [15:0] short_cnt;
  modport master (
    output init_calib_complete, wr_frame_start, wr_word_valid, rd_frame_start,
    input  wr_load, rd_load, wr_addr_min, wr_addr_max, rd_addr_min, rd_addr_max,
    input  wr_bank, rd_bank, frame_valid, ovw_cnt, short_cnt
  );
  modport slave (
    input  init_calib_complete, wr_frame_start, wr_word_valid, rd_frame_start,
    output wr_load, rd_load, wr_addr_min, wr_addr_max, rd_addr_min, rd_addr_max,
    output wr_bank, rd_bank, frame_valid, ovw_cnt, short_cnt
  );
endinterface

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer DDR3 bank scheduler (clk, reset, bus.slave: calib/start/word strobes in; load pulses, bank windows, frame_valid, ovw/short counters out)
module frame_buf_sched #(
  parameter int FRAME_WORDS = 2073600,
  parameter int FRAME_SPAN  = 2073600,
  parameter int BANK_STRIDE = 4194304
) (
  input logic           clk,
  input logic           reset,
  frame_buf_sched_if.slave bus
);
  typedef enum logic {WAIT_CALIB, RUN} top_t;
  typedef enum logic {W_IDLE, W_ACTIVE} wr_t;
  localparam logic [28:0] A1 = 29'(BANK_STRIDE);
  localparam logic [28:0] A2 = 29'(2 * BANK_STRIDE);
  localparam logic [28:0] M0 = 29'(FRAME_SPAN);
  localparam logic [28:0] M1 = 29'(BANK_STRIDE + FRAME_SPAN);
  localparam logic [28:0] M2 = 29'(2 * BANK_STRIDE + FRAME_SPAN);
  top_t        top;
  wr_t         wst;
  logic [23:0] cnt;
  logic [1:0]  latest;
  logic        fresh;
  logic        full, commit, take, run_ok;
  logic [1:0]  n_lat, n_rd, n_wr;
  function automatic logic [28:0] amin(input logic [1:0] b);
    return b == 2'd1 ? A1 : b == 2'd2 ? A2 : 29'd0;
  endfunction
  function automatic logic [28:0] amax(input logic [1:0] b);
    return b == 2'd1 ? M1 : b == 2'd2 ? M2 : M0;
  endfunction
  always_comb begin
    run_ok = top == RUN && bus.init_calib_complete;
    full   = wst == W_ACTIVE && cnt == 24'(FRAME_WORDS);
    commit = bus.wr_frame_start && full;
    take   = bus.rd_frame_start && (commit || fresh);
    n_lat  = commit ? bus.wr_bank : latest;
    n_rd   = take ? n_lat : bus.rd_bank;
    n_wr   = !commit ? bus.wr_bank : take ? bus.rd_bank : 2'd3 - bus.wr_bank - bus.rd_bank;
  end
  always_ff @(posedge clk) begin
    if (reset || !run_ok) begin
      top             <= (!reset && bus.init_calib_complete) ? RUN : WAIT_CALIB;
      wst             <= W_IDLE;
      cnt             <= '0;
      latest          <= '0;
      fresh           <= 1'b0;
      bus.wr_load     <= 1'b0;
      bus.rd_load     <= 1'b0;
      bus.wr_bank     <= 2'd0;
      bus.rd_bank     <= 2'd2;
      bus.wr_addr_min <= 29'd0;
      bus.wr_addr_max <= M0;
      bus.rd_addr_min <= A2;
      bus.rd_addr_max <= M2;
      bus.frame_valid <= 1'b0;
      if (reset) begin
        bus.ovw_cnt   <= '0;
        bus.short_cnt <= '0;
      end
    end else begin
      bus.wr_load     <= bus.wr_frame_start;
      bus.rd_load     <= bus.rd_frame_start;
      wst             <= bus.wr_frame_start ? W_ACTIVE : wst;
      cnt             <= bus.wr_frame_start ? '0 :
                         (wst == W_ACTIVE && bus.wr_word_valid && cnt != '1) ? cnt + 24'd1 : cnt;
      latest          <= n_lat;
      fresh           <= take ? 1'b0 : commit ? 1'b1 : fresh;
      bus.wr_bank     <= n_wr;
      bus.rd_bank     <= n_rd;
      bus.wr_addr_min <= amin(n_wr);
      bus.wr_addr_max <= amax(n_wr);
      bus.rd_addr_min <= amin(n_rd);
      bus.rd_addr_max <= amax(n_rd);
      bus.frame_valid <= bus.frame_valid | commit;
      bus.ovw_cnt     <= (commit && fresh && bus.ovw_cnt != '1) ? bus.ovw_cnt + 16'd1 : bus.ovw_cnt;
      bus.short_cnt   <= (bus.wr_frame_start && wst == W_ACTIVE && !full && bus.short_cnt != '1) ?
                         bus.short_cnt + 16'd1 : bus.short_cnt;
    end
  end
endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: table vectors plus randomized frames checked against a behavioural triple-buffer model
module tb_frame_buf_sched;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  frame_buf_sched_if bus();
  frame_buf_sched #(.FRAME_WORDS(16), .FRAME_SPAN(16), .BANK_STRIDE(64)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  int nvec = 0, nbad = 0;
  bit m_run, m_wact, m_unread, m_fv, m_wl, m_rl;
  int m_cnt, m_wr, m_rd, m_lat, m_ovw, m_short;
  typedef struct {
    int rep; bit c, w, v, r; bit ewl, erl; int ewr, erd; bit efv; int eovw, esh;
  } vec_t;
  vec_t tbl[23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input int lat, input int rd, input int old_rd);
    if (lat == rd) return old_rd;
    for (int b = 0; b < 3; b++) if (b != lat && b != rd) return b;
    return 0;
  endfunction
  task automatic model(input bit rs, input bit c, input bit w, input bit v, input bit r);
    bit committed = 0;
    int old_rd;
    if (rs || !(m_run && c)) begin
      m_wl = 0; m_rl = 0; m_wr = 0; m_rd = 2; m_unread = 0; m_fv = 0; m_cnt = 0; m_wact = 0;
      if (rs) begin m_ovw = 0; m_short = 0; end
      m_run = !rs && c;
    end else begin
      m_wl = w; m_rl = r;
      if (w) begin
        if (m_wact) begin
          if (m_cnt == 16) begin
            if (m_unread && m_ovw != 16'hFFFF) m_ovw++;
            m_lat = m_wr; m_unread = 1; m_fv = 1; committed = 1;
          end else if (m_short != 16'hFFFF) m_short++;
        end
        m_wact = 1; m_cnt = 0;
      end else if (m_wact && v && m_cnt < 24'hFFFFFF) m_cnt++;
      old_rd = m_rd;
      if (r && m_unread) begin m_rd = m_lat; m_unread = 0; end
      if (committed) m_wr = pick(m_lat, m_rd, old_rd);
    end
  endtask
  task automatic model_check();
    chk("wr_load", bus.wr_load, m_wl);
    chk("rd_load", bus.rd_load, m_rl);
    chk("wr_bank", bus.wr_bank, m_wr);
    chk("rd_bank", bus.rd_bank, m_rd);
    chk("wr_addr_min", bus.wr_addr_min, m_wr * 64);
    chk("wr_addr_max", bus.wr_addr_max, m_wr * 64 + 16);
    chk("rd_addr_min", bus.rd_addr_min, m_rd * 64);
    chk("rd_addr_max", bus.rd_addr_max, m_rd * 64 + 16);
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("ovw_cnt", bus.ovw_cnt, m_ovw);
    chk("short_cnt", bus.short_cnt, m_short);
    if (m_run) chk("wr_ne_rd", bus.wr_bank != bus.rd_bank, 1);
  endtask
  task automatic step(input bit rs, input bit c, input bit w, input bit v, input bit r);
    reset = rs;
    bus.init_calib_complete = c;
    bus.wr_frame_start = w;
    bus.wr_word_valid = v;
    bus.rd_frame_start = r;
    model(rs, c, w, v, r);
    @(posedge clk);
    #1;
    model_check();
  endtask
  initial begin
    bus.init_calib_complete = 0;
    bus.wr_frame_start = 0;
    bus.wr_word_valid = 0;
    bus.rd_frame_start = 0;
    tbl[0]  = '{1,  0,1,0,0, 0,0, 0,2, 0, 0,0};
    tbl[1]  = '{1,  0,0,0,1, 0,0, 0,2, 0, 0,0};
    tbl[2]  = '{1,  1,0,0,0, 0,0, 0,2, 0, 0,0};
    tbl[3]  = '{1,  1,1,0,0, 1,0, 0,2, 0, 0,0};
    tbl[4]  = '{1,  1,0,0,1, 0,1, 0,2, 0, 0,0};
    tbl[5]  = '{16, 1,0,1,0, 0,0, 0,2, 0, 0,0};
    tbl[6]  = '{1,  1,1,0,0, 1,0, 1,2, 1, 0,0};
    tbl[7]  = '{1,  1,0,0,1, 0,1, 1,0, 1, 0,0};
    tbl[8]  = '{15, 1,0,1,0, 0,0, 1,0, 1, 0,0};
    tbl[9]  = '{1,  1,1,0,0, 1,0, 1,0, 1, 0,1};
    tbl[10] = '{16, 1,0,1,0, 0,0, 1,0, 1, 0,1};
    tbl[11] = '{1,  1,1,0,0, 1,0, 2,0, 1, 0,1};
    tbl[12] = '{16, 1,0,1,0, 0,0, 2,0, 1, 0,1};
    tbl[13] = '{1,  1,1,0,0, 1,0, 1,0, 1, 1,1};
    tbl[14] = '{5,  1,0,1,0, 0,0, 1,0, 1, 1,1};
    tbl[15] = '{1,  0,0,1,0, 0,0, 0,2, 0, 1,1};
    tbl[16] = '{1,  1,0,0,0, 0,0, 0,2, 0, 1,1};
    tbl[17] = '{1,  1,1,0,0, 1,0, 0,2, 0, 1,1};
    tbl[18] = '{16, 1,0,1,0, 0,0, 0,2, 0, 1,1};
    tbl[19] = '{1,  1,1,0,0, 1,0, 1,2, 1, 1,1};
    tbl[20] = '{16, 1,0,1,0, 0,0, 1,2, 1, 1,1};
    tbl[21] = '{1,  1,1,0,1, 1,1, 2,1, 1, 2,1};
    tbl[22] = '{1,  1,0,0,1, 0,1, 2,1, 1, 2,1};
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("reset_rd_addr_min", bus.rd_addr_min, 128);
    chk("reset_wr_addr_max", bus.wr_addr_max, 16);
    for (int k = 0; k < 23; k++)
      for (int j = 0; j < tbl[k].rep; j++) begin
        step(0, tbl[k].c, tbl[k].w, tbl[k].v, tbl[k].r);
        chk($sformatf("t%0d_wr_load", k), bus.wr_load, tbl[k].ewl);
        chk($sformatf("t%0d_rd_load", k), bus.rd_load, tbl[k].erl);
        chk($sformatf("t%0d_wr_bank", k), bus.wr_bank, tbl[k].ewr);
        chk($sformatf("t%0d_rd_bank", k), bus.rd_bank, tbl[k].erd);
        chk($sformatf("t%0d_frame_valid", k), bus.frame_valid, tbl[k].efv);
        chk($sformatf("t%0d_ovw_cnt", k), bus.ovw_cnt, tbl[k].eovw);
        chk($sformatf("t%0d_short_cnt", k), bus.short_cnt, tbl[k].esh);
      end
    for (int f = 0; f < 150; f++) begin
      int n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 18)) : 16;
      if (f == 75) step(1, 1, 0, 0, 0);
      if ($urandom_range(0, 29) == 0) begin
        step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        step(0, 1, 0, 1, 0);
      end
      for (int i = 0; i < n;) begin
        bit v = $urandom_range(0, 3) != 0;
        step(0, 1, 0, v, $urandom_range(0, 9) == 0);
        if (v) i++;
      end
      step(0, 1, 1, 0, $urandom_range(0, 2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
